trena_envio_serial: RTL

- Transmission sequencer between the HC-SR04 interface and the 7E1 serial transmitter in the distance-meter (trena) datapath.
- On a send request, captures a BCD distance measurement (hundreds/tens/units) and converts each digit to 7-bit ASCII.
- Feeds the characters one at a time to the transmitter through a start/done handshake, most significant digit first, followed by a terminator character.
- Replaces the manual digit-selector mux plus external sequencing, so one request sends one complete measurement frame.

---
 rtl/trena_envio_serial.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/trena_envio_serial.sv
// Sends one captured BCD measurement as ASCII characters (MSD first, then terminator) through a start/done transmitter handshake.
// Optional build macro TRENA_ENVIO_CRLF_EN appends CR and LF after the terminator.
module trena_envio_serial #(
    parameter int         NUM_DIGITOS   = 3,
    parameter logic [6:0] CARACTERE_FIM = 7'h23
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     enviar,
    input  logic [4*NUM_DIGITOS-1:0] medida,
    input  logic                     tx_pronto,
    output logic                     tx_partida,
    output logic [6:0]               tx_dado,
    output logic                     ocupado,
    output logic                     pronto,
    output logic                     erro_digito,
    output logic [2:0]               estado
);

`ifdef TRENA_ENVIO_CRLF_EN
    localparam int NUM_CARACTERES = NUM_DIGITOS + 3;
`else
    localparam int NUM_CARACTERES = NUM_DIGITOS + 1;
`endif
    localparam int IDX_W = (NUM_CARACTERES > 1) ? $clog2(NUM_CARACTERES) : 1;
    localparam logic [IDX_W-1:0] IDX_FIM = IDX_W'(NUM_DIGITOS);
    localparam logic [IDX_W-1:0] ULTIMO  = IDX_W'(NUM_CARACTERES - 1);
`ifdef TRENA_ENVIO_CRLF_EN
    localparam logic [IDX_W-1:0] IDX_CR  = IDX_W'(NUM_DIGITOS + 1);
`endif

    // Handshake: tx_partida is a one-cycle start strobe with tx_dado already valid;
    // tx_pronto is honoured only while waiting in ESPERA, never in the start cycle.
    typedef enum logic [2:0] {
        INICIAL,
        PREPARA,
        TRANSMITE,
        ESPERA,
        PROXIMO,
        FIM
    } estado_t;

    estado_t                  estado_atual;
    estado_t                  estado_prox;
    logic [4*NUM_DIGITOS-1:0] captura;
    logic [IDX_W-1:0]         indice;
    logic [3:0]               digito;
    logic [6:0]               caractere;
    logic                     digito_invalido;

    assign estado = estado_atual;

    // Index 0 addresses the most significant nibble of the captured value.
    always_comb begin
        digito = 4'd0;
        for (int i = 0; i < NUM_DIGITOS; i++) begin
            if (indice == IDX_W'(NUM_DIGITOS - 1 - i)) begin
                digito = captura[4*i +: 4];
            end
        end
    end

    always_comb begin
        caractere       = CARACTERE_FIM;
        digito_invalido = 1'b0;
        if (indice < IDX_FIM) begin
            if (digito > 4'd9) begin
                caractere       = 7'h3F;
                digito_invalido = 1'b1;
            end else begin
                caractere = 7'h30 + {3'b000, digito};
            end
        end
`ifdef TRENA_ENVIO_CRLF_EN
        else if (indice == IDX_CR) begin
            caractere = 7'h0D;
        end else if (indice > IDX_CR) begin
            caractere = 7'h0A;
        end
`endif
    end

    always_comb begin
        estado_prox = estado_atual;
        case (estado_atual)
            INICIAL:   if (enviar) estado_prox = PREPARA;
            PREPARA:   estado_prox = TRANSMITE;
            TRANSMITE: estado_prox = ESPERA;
            ESPERA:    if (tx_pronto) estado_prox = PROXIMO;
            PROXIMO:   estado_prox = (indice == ULTIMO) ? FIM : PREPARA;
            FIM:       estado_prox = INICIAL;
            default:   estado_prox = INICIAL;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado_atual <= INICIAL;
        end else begin
            estado_atual <= estado_prox;
        end
    end

    // Strobes are registered from the next state so they align with the state they belong to.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            captura     <= '0;
            indice      <= '0;
            tx_dado     <= 7'h00;
            erro_digito <= 1'b0;
            tx_partida  <= 1'b0;
            ocupado     <= 1'b0;
            pronto      <= 1'b0;
        end else begin
            tx_partida <= (estado_prox == TRANSMITE);
            ocupado    <= (estado_prox != INICIAL);
            pronto     <= (estado_prox == FIM);
            case (estado_atual)
                INICIAL: begin
                    if (enviar) begin
                        captura     <= medida;
                        indice      <= '0;
                        erro_digito <= 1'b0;
                    end
                end
                PREPARA: begin
                    tx_dado <= caractere;
                    if (digito_invalido) begin
                        erro_digito <= 1'b1;
                    end
                end
                PROXIMO: begin
                    if (indice != ULTIMO) begin
                        indice <= indice + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
